// File: rtl/imem_refill_arbiter.sv
// imem_refill_arbiter
// Shares one byte-serial instruction memory (16 memory cycles per 128-bit block)
// between the active I-cache (port 0) and the standby I-cache (port 1).
// One refill is in flight at a time. mem_address is frozen for the whole refill.
// The returned block is registered per port. The owner sees a single-cycle busywait release.
// Build option: define IMEM_ARB_RR_EN for round-robin tie-breaking. Without it,
// port 0 wins every tie (fixed priority).
module imem_refill_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read0,
    input  logic [ADDR_W-1:0] address0,
    output logic [DATA_W-1:0] readdata0,
    output logic              busywait0,
    input  logic              read1,
    input  logic [ADDR_W-1:0] address1,
    output logic [DATA_W-1:0] readdata1,
    output logic              busywait1,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       owner;
    logic       any_req;
    logic       grant1;
    logic       grant;

`ifdef IMEM_ARB_RR_EN
    logic       last_grant;
`endif

    assign any_req = read0 || read1;
    // A grant is only ever taken in IDLE, so the address is sampled once per refill.
    assign grant   = (state == IDLE) && any_req;

    // Pick the winning port; only meaningful while any_req is high.
    always_comb begin
`ifdef IMEM_ARB_RR_EN
        if (read0 && read1) begin
            grant1 = !last_grant;
        end else begin
            grant1 = read1;
        end
`else
        grant1 = !read0;
`endif
    end

    // Next-state logic for the refill sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (!mem_busywait) state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // State, owner and the frozen memory address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            mem_address <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner       <= grant1;
                mem_address <= grant1 ? address1 : address0;
            end
        end
    end

`ifdef IMEM_ARB_RR_EN
    // Remember the most recent winner so the next tie goes the other way.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (grant) begin
            last_grant <= grant1;
        end
    end
`endif

    // Per-port block registers. They are loaded only when that port owns the refill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readdata0 <= '0;
            readdata1 <= '0;
        end else if (state == CAPTURE) begin
            if (owner) begin
                readdata1 <= mem_readdata;
            end else begin
                readdata0 <= mem_readdata;
            end
        end
    end

    assign mem_read  = (state == BUSY);
    // A port that has dropped its request is never stalled.
    assign busywait0 = read0 && !((state == DONE) && !owner);
    assign busywait1 = read1 && !((state == DONE) && owner);

endmodule

// File: tb/tb_imem_refill_arbiter.sv
// tb_imem_refill_arbiter
// Bench for imem_refill_arbiter. It contains:
// - a byte-serial memory model;
// - a timeline reference model, where every grant fixes mem_read for the next 16 cycles,
//   DONE at +18 and free again at +19;
// - a vector table;
// - directed corner sequences;
// - a randomized phase.
// It honours IMEM_ARB_RR_EN the same way the design does.
module tb_imem_refill_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;
    localparam logic [ADDR_W-1:0] AMAX = '1;

    logic              clock = 1'b0;
    logic              reset;
    logic              read0;
    logic              read1;
    logic [ADDR_W-1:0] address0;
    logic [ADDR_W-1:0] address1;
    logic [DATA_W-1:0] readdata0;
    logic [DATA_W-1:0] readdata1;
    logic              busywait0;
    logic              busywait1;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;
    logic [3:0]        mcnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    imem_refill_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .read0        (read0),
        .address0     (address0),
        .readdata0    (readdata0),
        .busywait0    (busywait0),
        .read1        (read1),
        .address1     (address1),
        .readdata1    (readdata1),
        .busywait1    (busywait1),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    // Preloaded memory contents, addressed by byte.
    function automatic logic [7:0] mem_byte(input logic [31:0] ba);
        logic [31:0] h;
        h = ba * 32'h9E3779B1;
        return h[31:24] ^ h[7:0] ^ 8'h3C;
    endfunction

    // Expected 128-bit block: bytes 0..15 of the block, little-endian.
    function automatic logic [DATA_W-1:0] block(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] b;
        for (int i = 0; i < 16; i++) b[i*8 +: 8] = mem_byte({a, 4'(i)});
        return b;
    endfunction

    // Byte-serial memory. Its counter resets from the same reset as the arbiter.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcnt         <= '0;
            mem_readdata <= '0;
        end else if (mem_read) begin
            mem_readdata[int'(mcnt)*8 +: 8] <= mem_byte({mem_address, mcnt});
            mcnt <= mcnt + 4'd1;
        end
    end
    assign mem_busywait = mem_read && (mcnt != 4'd15);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    int                cyc;
    bit                g_valid;
    int                g_cyc;
    bit                g_port;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] exp_rd0;
    logic [DATA_W-1:0] exp_rd1;
    bit                lg;
    bit                s_bw0, s_bw1, s_mr;

    task automatic model_reset();
        cyc     = 0;
        g_valid = 1'b0;
        g_cyc   = 0;
        g_port  = 1'b0;
        m_addr  = '0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        lg      = 1'b1;
    endtask

    task automatic model_step();
        int ph;
        bit busy, done, w;
        s_bw0 = busywait0;
        s_bw1 = busywait1;
        s_mr  = mem_read;
        if (!reset) begin
            chk("rst_busywait0", busywait0, read0);
            chk("rst_busywait1", busywait1, read1);
            chk("rst_mem_read", mem_read, 0);
            chk("rst_readdata0", readdata0, 0);
            model_reset();
            return;
        end
        ph   = cyc - g_cyc;
        busy = g_valid && ph >= 1 && ph <= 16;
        done = g_valid && ph == 18;
        chk("mem_read", mem_read, busy);
        chk("busywait0", busywait0, read0 && !(done && g_port == 1'b0));
        chk("busywait1", busywait1, read1 && !(done && g_port == 1'b1));
        chk("mem_address", mem_address, m_addr);
        chk("readdata0", readdata0, exp_rd0);
        chk("readdata1", readdata1, exp_rd1);
        if (g_valid && ph == 17) begin
            if (g_port) exp_rd1 = block(m_addr);
            else        exp_rd0 = block(m_addr);
        end
        if ((!g_valid || ph >= 19) && (read0 || read1)) begin
            if (read0 && read1) begin
`ifdef IMEM_ARB_RR_EN
                w = (lg == 1'b0);
`else
                w = 1'b0;
`endif
            end else begin
                w = read1;
            end
            g_valid = 1'b1;
            g_cyc   = cyc;
            g_port  = w;
            m_addr  = w ? address1 : address0;
            lg      = w;
        end
        cyc++;
    endtask

    // One clock: sample and check at the falling edge, then return just after the rising edge.
    task automatic step();
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input bit p, output int nhigh, output int nmr);
        nhigh = 0;
        nmr   = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (s_mr) nmr++;
            if ((p ? s_bw1 : s_bw0) == 1'b0) return;
            nhigh++;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: port %0d busywait still high after 60 cycles, required low", p);
    endtask

    task automatic wait_any(output bit p, output int nhigh);
        nhigh = 0;
        p     = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (read0 && !s_bw0) begin p = 1'b0; return; end
            if (read1 && !s_bw1) begin p = 1'b1; return; end
            nhigh++;
        end
        checks++;
        errors++;
        $display("FAIL any_timeout: no busywait release after 60 cycles, required one");
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return '0;
        if (r == 1) return AMAX;
        return ADDR_W'($urandom);
    endfunction

    typedef struct {
        bit                r0;
        bit                r1;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        bit                first_fixed;
        bit                first_rr;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                nh, nm, cnt;
        bit                p;
        bit                exp_first;
        logic [DATA_W-1:0] first_data;

        tbl[0] = '{r0: 1'b1, r1: 1'b1, a0: 28'h1,       a1: 28'h2,       first_fixed: 1'b0, first_rr: 1'b1};
        tbl[1] = '{r0: 1'b0, r1: 1'b1, a0: 28'h0,       a1: AMAX,        first_fixed: 1'b1, first_rr: 1'b1};
        tbl[2] = '{r0: 1'b1, r1: 1'b1, a0: AMAX,        a1: 28'h0,       first_fixed: 1'b0, first_rr: 1'b0};
        tbl[3] = '{r0: 1'b1, r1: 1'b0, a0: 28'h5555555, a1: 28'h0,       first_fixed: 1'b0, first_rr: 1'b0};
        tbl[4] = '{r0: 1'b1, r1: 1'b1, a0: 28'hABCDEF1, a1: 28'h1234567, first_fixed: 1'b0, first_rr: 1'b1};

        // Reset state; busywait follows read while in reset.
        reset    = 1'b0;
        read0    = 1'b1;
        read1    = 1'b0;
        address0 = '0;
        address1 = '0;
        model_reset();
        #2;
        chk("reset_mem_read", mem_read, 0);
        chk("reset_mem_address", mem_address, 0);
        chk("reset_readdata0", readdata0, 0);
        chk("reset_readdata1", readdata1, 0);
        chk("reset_busywait0", busywait0, 1);
        chk("reset_busywait1", busywait1, 0);
        step();
        read0 = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Single port-0 refill of block 0.
        read0    = 1'b1;
        address0 = '0;
        wait_done(1'b0, nh, nm);
        chk("single_busy_cycles", nh, 18);
        chk("single_mem_read_cycles", nm, 16);
        chk("single_data", readdata0, block('0));
        read0 = 1'b0;
        step();

        // Vector table
        for (int i = 0; i < 5; i++) begin
            read0    = tbl[i].r0;
            read1    = tbl[i].r1;
            address0 = tbl[i].a0;
            address1 = tbl[i].a1;
`ifdef IMEM_ARB_RR_EN
            exp_first = tbl[i].first_rr;
`else
            exp_first = tbl[i].first_fixed;
`endif
            wait_any(p, nh);
            chk("vec_first_port", p, exp_first);
            chk("vec_first_latency", nh, 18);
            first_data = p ? readdata1 : readdata0;
            chk("vec_first_data", first_data, block(p ? tbl[i].a1 : tbl[i].a0));
            if (p) read1 = 1'b0;
            else   read0 = 1'b0;
            if (tbl[i].r0 && tbl[i].r1) begin
                wait_done(!p, nh, nm);
                chk("vec_second_latency", nh, 18);
                chk("vec_second_data", p ? readdata0 : readdata1, block(p ? tbl[i].a0 : tbl[i].a1));
                chk("vec_first_kept", p ? readdata1 : readdata0, first_data);
                if (p) read0 = 1'b0;
                else   read1 = 1'b0;
            end
            step();
        end

        // Port 1 arrives and changes address while port 0 is being served.
        read0    = 1'b1;
        address0 = 28'h0000AAA;
        read1    = 1'b0;
        address1 = 28'h0000111;
        step();
        step();
        step();
        read1 = 1'b1;
        step();
        step();
        step();
        address1 = 28'h0000222;
        wait_done(1'b0, nh, nm);
        chk("addrchg_mem_address", mem_address, 28'h0000AAA);
        chk("addrchg_data0", readdata0, block(28'h0000AAA));
        read0 = 1'b0;
        wait_done(1'b1, nh, nm);
        chk("addrchg_latency1", nh, 18);
        chk("addrchg_data1", readdata1, block(28'h0000222));
        read1 = 1'b0;
        step();

        // Reset in the 8th BUSY cycle.
        read0    = 1'b1;
        address0 = 28'h0000777;
        for (int k = 0; k < 8; k++) step();
        reset = 1'b0;
        #1;
        chk("midrst_mem_read", mem_read, 0);
        chk("midrst_readdata0", readdata0, 0);
        chk("midrst_readdata1", readdata1, 0);
        chk("midrst_mem_address", mem_address, 0);
        step();
        reset = 1'b1;
        wait_done(1'b0, nh, nm);
        chk("postrst_latency", nh, 18);
        chk("postrst_mem_read_cycles", nm, 16);
        chk("postrst_data", readdata0, block(28'h0000777));
        read0 = 1'b0;
        step();

        // Port 0 drops read0 in the 5th BUSY cycle.
        read0    = 1'b1;
        address0 = 28'h0F0F0F0;
        nm       = 0;
        cnt      = 0;
        for (int k = 0; k < 19; k++) begin
            if (k == 5) read0 = 1'b0;
            step();
            if (s_mr) nm++;
            if (k >= 5 && s_bw0) cnt++;
        end
        chk("drop_mem_read_cycles", nm, 16);
        chk("drop_busywait0_low", cnt, 0);
        chk("drop_data", readdata0, block(28'h0F0F0F0));
        read1    = 1'b1;
        address1 = 28'h3333333;
        wait_done(1'b1, nh, nm);
        chk("drop_regrant_latency", nh, 18);
        read1 = 1'b0;
        step();

        // Randomized traffic that obeys the hold-until-released protocol.
        for (int k = 0; k < 4000; k++) begin
            if (read0 && !s_bw0) begin
                read0    = 1'($urandom_range(0, 1));
                address0 = rand_addr();
            end else if (!read0 && $urandom_range(0, 2) == 0) begin
                read0    = 1'b1;
                address0 = rand_addr();
            end
            if (read1 && !s_bw1) begin
                read1    = 1'($urandom_range(0, 1));
                address1 = rand_addr();
            end else if (!read1 && $urandom_range(0, 2) == 0) begin
                read1    = 1'b1;
                address1 = rand_addr();
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
